// File: rtl/fwrisc_bus_pkg.sv
// Shared definitions for the fwrisc memory-bus arbiter and its watchdog.
package fwrisc_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int ARB_FIXED_D = 0;
  localparam int ARB_RR      = 1;

endpackage

// File: rtl/fwrisc_bus_watchdog.sv
// Per-transaction watchdog: counts stalled bus cycles and flags a hung access.
module fwrisc_bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIMIT_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIMIT = LIMIT_I[CW-1:0];

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A TIMEOUT of zero turns the watchdog off entirely.
  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign timeout = 1'b0;
    end else begin : g_enabled
      assign timeout = enable && (count_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/fwrisc_bus_arbiter.sv
// Shares the core memory bus between the fetch port and the data port,
// one registered transaction at a time, with a watchdog for hung accesses.
module fwrisc_bus_arbiter
  import fwrisc_bus_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        busy,
  output logic        grant_d
);

  arb_state_e  state_q, state_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        m_write_q, m_write_d;
  logic [3:0]  m_wstb_q, m_wstb_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;

  logic pick;
  logic take;
  logic done;
  logic wd_enable;
  logic wd_timeout;
  logic resp_fire;

  // In round-robin mode a contested grant goes to whoever lost last time.
  always_comb begin
    if (i_valid && d_valid) begin
      if (ARB_MODE == ARB_FIXED_D) begin
        pick = PORT_D;
      end else begin
        pick = (last_grant_q == PORT_D) ? PORT_I : PORT_D;
      end
    end else begin
      pick = d_valid ? PORT_D : PORT_I;
    end
  end

  assign take      = (state_q == IDLE) && (i_valid || d_valid);
  assign wd_enable = (state_q == BUSY) && !m_ready;
  assign done      = (state_q == BUSY) && (m_ready || wd_timeout);

  always_comb begin
    state_d      = state_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_write_d    = m_write_q;
    m_wstb_d     = m_wstb_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    if (take) begin
      state_d      = BUSY;
      gnt_d        = pick;
      last_grant_d = pick;
      if (pick == PORT_D) begin
        m_addr_d  = d_addr;
        m_write_d = d_write;
        m_wdata_d = d_wdata;
        m_wstb_d  = d_wstb;
      end else begin
        m_addr_d  = i_addr;
        m_write_d = 1'b0;
        m_wdata_d = '0;
        m_wstb_d  = '0;
      end
    end else if (done) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_write_q    <= 1'b0;
      m_wstb_q     <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= PORT_D;
    end else begin
      state_q      <= state_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_write_q    <= m_write_d;
      m_wstb_q     <= m_wstb_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  fwrisc_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (take),
    .enable  (wd_enable),
    .timeout (wd_timeout)
  );

  // Reset gates the response so an abandoned transaction never reports back.
  always_comb begin
    resp_fire = done && !reset;
    i_ready   = resp_fire && (gnt_q == PORT_I);
    d_ready   = resp_fire && (gnt_q == PORT_D);
    i_err     = i_ready && !m_ready;
    d_err     = d_ready && !m_ready;
    i_rdata   = (i_ready && m_ready) ? m_rdata : '0;
    d_rdata   = (d_ready && m_ready) ? m_rdata : '0;
  end

  assign m_valid = (state_q == BUSY);
  assign busy    = (state_q == BUSY);
  assign grant_d = gnt_q;
  assign m_addr  = m_addr_q;
  assign m_write = m_write_q;
  assign m_wdata = m_wdata_q;
  assign m_wstb  = m_wstb_q;

endmodule

// File: tb/tb_fwrisc_bus_arbiter.sv
// Scoreboard bench for fwrisc_bus_arbiter: a fixed-priority and a round-robin
// instance share stimulus; sel picks which one the memory model serves.
module tb_fwrisc_bus_arbiter;
  import fwrisc_bus_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic [31:0] rdata;
    int          lat;
    logic        timeout;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic        i_valid, d_valid, d_write, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wstb;

  logic        i_ready_w [2];
  logic [31:0] i_rdata_w [2];
  logic        i_err_w   [2];
  logic        d_ready_w [2];
  logic [31:0] d_rdata_w [2];
  logic        d_err_w   [2];
  logic        m_valid_w [2];
  logic [31:0] m_addr_w  [2];
  logic        m_write_w [2];
  logic [31:0] m_wdata_w [2];
  logic [3:0]  m_wstb_w  [2];
  logic        busy_w    [2];
  logic        grant_d_w [2];

  logic        i_ready, i_err, d_ready, d_err, m_valid, m_write, busy, grant_d;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstb;

  txn_t iq[$];
  txn_t dq[$];
  txn_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fwrisc_bus_arbiter #(.ARB_MODE(ARB_FIXED_D), .TIMEOUT(255)) u_dut_fixed (
    .clock(clock), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready_w[0]), .i_rdata(i_rdata_w[0]), .i_err(i_err_w[0]),
    .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata), .d_wstb(d_wstb),
    .d_ready(d_ready_w[0]), .d_rdata(d_rdata_w[0]), .d_err(d_err_w[0]),
    .m_valid(m_valid_w[0]), .m_addr(m_addr_w[0]), .m_write(m_write_w[0]), .m_wdata(m_wdata_w[0]),
    .m_wstb(m_wstb_w[0]), .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy_w[0]), .grant_d(grant_d_w[0])
  );

  fwrisc_bus_arbiter #(.ARB_MODE(ARB_RR), .TIMEOUT(TO)) u_dut_rr (
    .clock(clock), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready_w[1]), .i_rdata(i_rdata_w[1]), .i_err(i_err_w[1]),
    .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata), .d_wstb(d_wstb),
    .d_ready(d_ready_w[1]), .d_rdata(d_rdata_w[1]), .d_err(d_err_w[1]),
    .m_valid(m_valid_w[1]), .m_addr(m_addr_w[1]), .m_write(m_write_w[1]), .m_wdata(m_wdata_w[1]),
    .m_wstb(m_wstb_w[1]), .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy_w[1]), .grant_d(grant_d_w[1])
  );

  assign i_ready = i_ready_w[sel];
  assign i_rdata = i_rdata_w[sel];
  assign i_err   = i_err_w[sel];
  assign d_ready = d_ready_w[sel];
  assign d_rdata = d_rdata_w[sel];
  assign d_err   = d_err_w[sel];
  assign m_valid = m_valid_w[sel];
  assign m_addr  = m_addr_w[sel];
  assign m_write = m_write_w[sel];
  assign m_wdata = m_wdata_w[sel];
  assign m_wstb  = m_wstb_w[sel];
  assign busy    = busy_w[sel];
  assign grant_d = grant_d_w[sel];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic txn_t mkTxn(input logic port, input logic [31:0] addr, input logic write,
                                 input logic [31:0] wdata, input logic [3:0] wstb,
                                 input logic [31:0] rdata, input int lat, input logic to);
    txn_t t;
    t.port    = port;
    t.addr    = addr;
    t.write   = write;
    t.wdata   = wdata;
    t.wstb    = wstb;
    t.rdata   = rdata;
    t.lat     = lat;
    t.timeout = to;
    return t;
  endfunction

  // Present the head of each port queue; an empty data port carries junk
  // that a fetch grant must not leak onto the bus.
  task automatic driveRequests();
    if (iq.size() > 0) begin
      i_valid = 1'b1;
      i_addr  = iq[0].addr;
    end else begin
      i_valid = 1'b0;
      i_addr  = $urandom();
    end
    if (dq.size() > 0) begin
      d_valid = 1'b1;
      d_addr  = dq[0].addr;
      d_write = dq[0].write;
      d_wdata = dq[0].wdata;
      d_wstb  = dq[0].wstb;
    end else begin
      d_valid = 1'b0;
      d_addr  = $urandom();
      d_write = 1'b1;
      d_wdata = $urandom();
      d_wstb  = 4'hF;
    end
  endtask

  task automatic applyStimulus();
    txn_t e;
    logic fire;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      driveRequests();
      m_ready = 1'b0;
      #1;
      checkOutput("idle_m_valid", m_valid, 0);
      checkOutput("idle_ready", {i_ready, d_ready}, 0);
      e = exp_q.pop_front();
      for (int c = 0; c <= e.lat + TO; c++) begin
        @(negedge clock);
        fire    = e.timeout ? (c == TO - 1) : (c == e.lat);
        m_ready = !e.timeout && (c == e.lat);
        m_rdata = m_ready ? e.rdata : $urandom();
        #1;
        checkOutput("m_valid", m_valid, 1);
        checkOutput("busy", busy, 1);
        checkOutput("grant_d", grant_d, e.port);
        checkOutput("m_addr", m_addr, e.addr);
        checkOutput("m_write", m_write, e.write);
        checkOutput("m_wstb", m_wstb, e.wstb);
        if (e.port == PORT_D) begin
          checkOutput("m_wdata", m_wdata, e.wdata);
          checkOutput("d_ready", d_ready, fire);
          checkOutput("d_err", d_err, fire && e.timeout);
          checkOutput("iso_i", {i_ready, i_err}, 0);
          checkOutput("iso_i_rdata", i_rdata, 0);
          if (fire) checkOutput("d_rdata", d_rdata, e.timeout ? 32'h0 : e.rdata);
        end else begin
          checkOutput("i_ready", i_ready, fire);
          checkOutput("i_err", i_err, fire && e.timeout);
          checkOutput("iso_d", {d_ready, d_err}, 0);
          checkOutput("iso_d_rdata", d_rdata, 0);
          if (fire) checkOutput("i_rdata", i_rdata, e.timeout ? 32'h0 : e.rdata);
        end
        if (fire) break;
      end
      if (e.port == PORT_D) begin
        if (dq.size() > 0) dq.delete(0);
      end else begin
        if (iq.size() > 0) iq.delete(0);
      end
    end
    @(negedge clock);
    driveRequests();
    m_ready = 1'b0;
    #1;
    checkOutput("after_m_valid", m_valid, 0);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset   = 1'b1;
    i_valid = 1'b0;
    d_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_grant_d", grant_d, 0);
    reset = 1'b0;
  endtask

  initial begin
    txn_t t;
    reset   = 1'b1;
    sel     = 1'b1;
    i_valid = 1'b0;
    i_addr  = '0;
    d_valid = 1'b0;
    d_addr  = '0;
    d_write = 1'b0;
    d_wdata = '0;
    d_wstb  = '0;
    m_ready = 1'b0;
    m_rdata = '0;

    repeat (2) @(negedge clock);
    #1;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant_d", grant_d, 0);
    checkOutput("rst_m_addr", m_addr, 0);
    checkOutput("rst_m_wdata", m_wdata, 0);
    checkOutput("rst_m_wstb", m_wstb, 0);
    checkOutput("rst_m_write", m_write, 0);
    checkOutput("rst_ready_err", {i_ready, i_err, d_ready, d_err}, 0);
    reset = 1'b0;

    $display("[TB] lone fetch");
    t = mkTxn(PORT_I, 32'h100, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 2, 1'b0);
    iq.push_back(t);
    exp_q.push_back(t);
    applyStimulus();

    $display("[TB] round-robin alternation from reset");
    doReset();
    for (int k = 0; k < 2; k++) begin
      t = mkTxn(PORT_I, 32'h1000 + 32'(k * 4), 1'b0, 32'h0, 4'h0, 32'hA0000000 + 32'(k), k, 1'b0);
      iq.push_back(t);
      exp_q.push_back(t);
      t = mkTxn(PORT_D, 32'h2000 + 32'(k * 4), 1'b0, 32'h11110000 + 32'(k), 4'hF, 32'hB0000000 + 32'(k), 1 - k, 1'b0);
      dq.push_back(t);
      exp_q.push_back(t);
    end
    applyStimulus();

    $display("[TB] m_ready on the watchdog limit cycle");
    t = mkTxn(PORT_D, 32'h2800, 1'b0, 32'h0, 4'hF, 32'h600DF00D, TO - 1, 1'b0);
    dq.push_back(t);
    exp_q.push_back(t);
    applyStimulus();

    $display("[TB] watchdog timeout");
    t = mkTxn(PORT_D, 32'h3000, 1'b0, 32'h0, 4'hF, 32'h0, 0, 1'b1);
    dq.push_back(t);
    exp_q.push_back(t);
    applyStimulus();
    t = mkTxn(PORT_I, 32'h400, 1'b0, 32'h0, 4'h0, 32'h0BADCAFE, 0, 1'b0);
    iq.push_back(t);
    exp_q.push_back(t);
    applyStimulus();

    $display("[TB] reset while busy");
    @(negedge clock);
    i_valid = 1'b1;
    i_addr  = 32'h500;
    d_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("rmid_m_valid", m_valid, 1);
    @(negedge clock);
    reset   = 1'b1;
    m_ready = 1'b1;
    m_rdata = 32'h55AA55AA;
    #1;
    checkOutput("rmid_no_ready", {i_ready, d_ready, i_err, d_err}, 0);
    @(negedge clock);
    reset   = 1'b0;
    m_ready = 1'b0;
    i_valid = 1'b0;
    #1;
    checkOutput("rmid_m_valid_drop", m_valid, 0);
    checkOutput("rmid_busy_drop", busy, 0);
    checkOutput("rmid_ready_after", {i_ready, d_ready}, 0);
    t = mkTxn(PORT_I, 32'h600, 1'b0, 32'h0, 4'h0, 32'h13572468, 1, 1'b0);
    iq.push_back(t);
    exp_q.push_back(t);
    applyStimulus();

    $display("[TB] fixed priority: store held stable");
    sel = 1'b0;
    doReset();
    t = mkTxn(PORT_D, 32'h2004, 1'b1, 32'h12345678, 4'b0011, 32'hCAFE0001, 5, 1'b0);
    dq.push_back(t);
    exp_q.push_back(t);
    applyStimulus();

    $display("[TB] fixed priority: data before fetch");
    for (int k = 0; k < 3; k++) begin
      t = mkTxn(PORT_D, 32'h4000 + 32'(k * 4), k[0], 32'h77000000 + 32'(k), 4'hF - 4'(k), 32'hD0000000 + 32'(k), k, 1'b0);
      dq.push_back(t);
      exp_q.push_back(t);
    end
    for (int k = 0; k < 3; k++) begin
      t = mkTxn(PORT_I, 32'h5000 + 32'(k * 4), 1'b0, 32'h0, 4'h0, 32'hE0000000 + 32'(k), 2 - k, 1'b0);
      iq.push_back(t);
      exp_q.push_back(t);
    end
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
